pls_increment_table_calc: RTL and testbench
===========================================

// Module: pls_increment_table_calc
// PURPOSE
//  Batch successor of the single-segment increment calculator: for segments i = 0..N-1 computes
//  inc[i] = (a[i] - b[i]) / lines[i] in floating point using external AXI-Stream FP subtractor and
//  divider cores. Operands come from a 1-cycle-latency segment table read port. Results go to an
//  increment table write port. Sits in the configurating path between segment RAM and the generator core.
// PARAMETERS
//  DATA_SIZE  32            operand/result width (IEEE-754 single at 32)
//  SEG_COUNT  8             max segments per batch (>=1)
//  IDX_W      $clog2(SEG_COUNT) (min 1)  segment index width
//  LINES_ONE  32'h3F80_0000 encoding of 1.0; lines equal to it bypass the divider
// PORTS
//  aclk                     in   1          clock
//  aresetn                  in   1          async active-low reset
//  start                    in   1          level request; sampled in IDLE
//  seg_num                  in   IDX_W+1    segments to process; latched when start is accepted
//  busy / done              out  1 / 1      busy level; done = 1-cycle pulse at batch end
//  err / err_seg            out  1 / IDX_W  sticky lines==0 flag; first offending index
//  rd_en / rd_addr          out  1 / IDX_W  table read; data valid the cycle after rd_en
//  rd_a / rd_b / rd_lines   in   DATA_SIZE  segment operands
//  wr_en/wr_addr/wr_data    out  1/IDX_W/DATA_SIZE  increment write strobe
//  sub_a_t{valid,ready,data}  out/in/out  1/1/DATA_SIZE  subtractor operand A (minuend)
//  sub_b_t{valid,ready,data}  out/in/out  1/1/DATA_SIZE  subtractor operand B
//  sub_r_t{valid,ready,data}  in/out/in   1/1/DATA_SIZE  subtractor result
//  div_a_t…, div_b_t…, div_r_t…  same shape; dividend, divisor, quotient
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; every output 0, incl. all tvalid/tready, err, err_seg.
//  FSM: IDLE -> RD -> RD_WAIT -> SUB_REQ -> SUB_RESP -> [DIV_REQ -> DIV_RESP] -> WR -> (RD | DONE).
//  IDLE: start=1 -> latch n=min(seg_num,SEG_COUNT), idx=0, clear err/err_seg; n==0 -> DONE directly.
//  RD: rd_en=1, rd_addr=idx (1 cycle). RD_WAIT: register rd_a, rd_b, rd_lines.
//  SUB_REQ: sub_a_tvalid and sub_b_tvalid raised together; each channel independent: drops its
//   tvalid the cycle after its own tvalid&tready; tdata stable while tvalid=1. Leave when both accepted.
//  SUB_RESP: sub_r_tready=1; capture tdata on tvalid -> diff.
//  Branch on registered lines: lines[DATA_SIZE-2:0]==0 (+/-0.0) -> result=0, set err, err_seg=idx
//   only if err was 0; skip divider. lines==LINES_ONE -> result=diff, skip divider.
//   Otherwise DIV_REQ (div_a=diff, div_b=lines, same handshake rules) -> DIV_RESP captures quotient.
//  WR: wr_en=1 one cycle, wr_addr=idx, wr_data=result. idx==n-1 -> DONE, else idx++ -> RD.
//  DONE: done=1 on entry cycle only; stay until start=0, then IDLE. err/err_seg hold until next start.
//  busy=1 in every state except IDLE and DONE (registered, 1-cycle lag like state).
//  Min latency per divided segment with zero-wait cores: 7 cycles; bypassed segment: 5.
//  Exactly one sub transaction per segment; at most one div transaction; never a second operand beat
//   before the previous result is consumed. Errors do not abort the batch; all n entries written.
//  start changes while busy: ignored. Result tvalid outside *_RESP: not consumed (tready=0).
//  aresetn low mid-batch: all tvalid/tready/wr_en drop immediately; no partial write; after release
//   the next start restarts at idx 0 (external cores are reset from the same aresetn).
// TESTING
//  1 n=1: a=40A00000(5.0) b=3F800000(1.0) lines=40800000(4.0) -> sub sees 5.0,1.0; div sees 4.0,4.0;
//    wr_addr=0 wr_data=3F800000; done pulses once; busy falls same cycle done rises.
//  2 n=3, seg1 lines=3F800000 -> exactly 2 div transactions; wr_data[1]=sub result of seg1 unchanged.
//  3 n=4, seg2 lines=80000000(-0.0), seg3 lines=0 -> wr_data[2]=wr_data[3]=0, err=1, err_seg=2,
//    four writes; err cleared by next start.
//  4 Backpressure: sub_a_tready held 0 for 5 cycles, sub_b_tready=1 -> sub_b_tvalid 1 cycle only,
//    sub_a_tdata stable 6 cycles; div_r_tvalid delayed 10 cycles -> correct wr_data, no extra beats.
//  5 aresetn low during DIV_RESP of seg1 -> outputs 0 immediately, no wr_en; restart n=2 -> writes idx 0,1.
//  6 seg_num=0 -> done pulse 1 cycle after start accepted, no rd/wr; seg_num=15 (SEG_COUNT=8) -> 8 writes.

Source files
------------

// File: rtl/pls_increment_table_calc.sv
// Batch increment calculator: inc[i] = (a[i] - b[i]) / lines[i] for segments 0..n-1,
// driving external AXI-Stream FP subtractor/divider cores and a segment/increment table pair.
module pls_increment_table_calc #(
  parameter int                    DATA_SIZE = 32,
  parameter int                    SEG_COUNT = 8,
  parameter int                    IDX_W     = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1,
  parameter logic [DATA_SIZE-1:0]  LINES_ONE = 32'h3F80_0000
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [IDX_W:0]       seg_num,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_seg,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_addr,
  input  logic [DATA_SIZE-1:0] rd_a,
  input  logic [DATA_SIZE-1:0] rd_b,
  input  logic [DATA_SIZE-1:0] rd_lines,
  output logic                 wr_en,
  output logic [IDX_W-1:0]     wr_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 sub_a_tvalid,
  input  logic                 sub_a_tready,
  output logic [DATA_SIZE-1:0] sub_a_tdata,
  output logic                 sub_b_tvalid,
  input  logic                 sub_b_tready,
  output logic [DATA_SIZE-1:0] sub_b_tdata,
  input  logic                 sub_r_tvalid,
  output logic                 sub_r_tready,
  input  logic [DATA_SIZE-1:0] sub_r_tdata,
  output logic                 div_a_tvalid,
  input  logic                 div_a_tready,
  output logic [DATA_SIZE-1:0] div_a_tdata,
  output logic                 div_b_tvalid,
  input  logic                 div_b_tready,
  output logic [DATA_SIZE-1:0] div_b_tdata,
  input  logic                 div_r_tvalid,
  output logic                 div_r_tready,
  input  logic [DATA_SIZE-1:0] div_r_tdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_RD_WAIT, S_SUB_REQ, S_SUB_RESP,
    S_DIV_REQ, S_DIV_RESP, S_WR, S_DONE
  } state_t;

  localparam logic [IDX_W:0] SEG_MAX = (IDX_W+1)'(SEG_COUNT);

  state_t               state;
  logic [IDX_W:0]       n;
  logic [IDX_W-1:0]     idx;
  logic [DATA_SIZE-1:0] lines_r;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      n            <= '0;
      idx          <= '0;
      lines_r      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_seg      <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      sub_a_tvalid <= 1'b0;
      sub_a_tdata  <= '0;
      sub_b_tvalid <= 1'b0;
      sub_b_tdata  <= '0;
      sub_r_tready <= 1'b0;
      div_a_tvalid <= 1'b0;
      div_a_tdata  <= '0;
      div_b_tvalid <= 1'b0;
      div_b_tdata  <= '0;
      div_r_tready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            err     <= 1'b0;
            err_seg <= '0;
            n       <= (seg_num > SEG_MAX) ? SEG_MAX : seg_num;
            if (seg_num == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_RD;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        S_RD: begin
          rd_en <= 1'b0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          lines_r      <= rd_lines;
          sub_a_tdata  <= rd_a;
          sub_b_tdata  <= rd_b;
          sub_a_tvalid <= 1'b1;
          sub_b_tvalid <= 1'b1;
          state        <= S_SUB_REQ;
        end
        // A channel whose tvalid is already low was accepted on an earlier cycle.
        S_SUB_REQ: begin
          if (sub_a_tready) sub_a_tvalid <= 1'b0;
          if (sub_b_tready) sub_b_tvalid <= 1'b0;
          if ((!sub_a_tvalid || sub_a_tready) && (!sub_b_tvalid || sub_b_tready)) begin
            sub_r_tready <= 1'b1;
            state        <= S_SUB_RESP;
          end
        end
        S_SUB_RESP: begin
          if (sub_r_tvalid) begin
            sub_r_tready <= 1'b0;
            if (lines_r[DATA_SIZE-2:0] == '0) begin
              wr_data <= '0;
              err     <= 1'b1;
              if (!err) err_seg <= idx;
              wr_en   <= 1'b1;
              wr_addr <= idx;
              state   <= S_WR;
            end else if (lines_r == LINES_ONE) begin
              wr_data <= sub_r_tdata;
              wr_en   <= 1'b1;
              wr_addr <= idx;
              state   <= S_WR;
            end else begin
              div_a_tdata  <= sub_r_tdata;
              div_b_tdata  <= lines_r;
              div_a_tvalid <= 1'b1;
              div_b_tvalid <= 1'b1;
              state        <= S_DIV_REQ;
            end
          end
        end
        S_DIV_REQ: begin
          if (div_a_tready) div_a_tvalid <= 1'b0;
          if (div_b_tready) div_b_tvalid <= 1'b0;
          if ((!div_a_tvalid || div_a_tready) && (!div_b_tvalid || div_b_tready)) begin
            div_r_tready <= 1'b1;
            state        <= S_DIV_RESP;
          end
        end
        S_DIV_RESP: begin
          if (div_r_tvalid) begin
            div_r_tready <= 1'b0;
            wr_data      <= div_r_tdata;
            wr_en        <= 1'b1;
            wr_addr      <= idx;
            state        <= S_WR;
          end
        end
        S_WR: begin
          wr_en <= 1'b0;
          if ({1'b0, idx} == n - 1'b1) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx     <= idx + 1'b1;
            rd_addr <= idx + 1'b1;
            rd_en   <= 1'b1;
            state   <= S_RD;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pls_increment_table_calc.sv
// Directed bench for pls_increment_table_calc with behavioural table and FP core stand-ins.
module tb_pls_increment_table_calc;
  localparam int DW = 32;
  localparam int SC = 8;
  localparam int IW = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   seg_num = '0;
  logic          busy, done, err, rd_en, wr_en;
  logic [IW-1:0] err_seg, rd_addr, wr_addr;
  logic [DW-1:0] rd_a = '0, rd_b = '0, rd_lines = '0, wr_data;
  logic          sub_a_tvalid, sub_a_tready, sub_b_tvalid, sub_b_tready;
  logic          sub_r_tvalid = 1'b0, sub_r_tready;
  logic [DW-1:0] sub_a_tdata, sub_b_tdata, sub_r_tdata = '0;
  logic          div_a_tvalid, div_a_tready, div_b_tvalid, div_b_tready;
  logic          div_r_tvalid = 1'b0, div_r_tready;
  logic [DW-1:0] div_a_tdata, div_b_tdata, div_r_tdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  pls_increment_table_calc #(.DATA_SIZE(DW), .SEG_COUNT(SC)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .seg_num(seg_num),
    .busy(busy), .done(done), .err(err), .err_seg(err_seg),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b), .rd_lines(rd_lines),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sub_a_tvalid(sub_a_tvalid), .sub_a_tready(sub_a_tready), .sub_a_tdata(sub_a_tdata),
    .sub_b_tvalid(sub_b_tvalid), .sub_b_tready(sub_b_tready), .sub_b_tdata(sub_b_tdata),
    .sub_r_tvalid(sub_r_tvalid), .sub_r_tready(sub_r_tready), .sub_r_tdata(sub_r_tdata),
    .div_a_tvalid(div_a_tvalid), .div_a_tready(div_a_tready), .div_a_tdata(div_a_tdata),
    .div_b_tvalid(div_b_tvalid), .div_b_tready(div_b_tready), .div_b_tdata(div_b_tdata),
    .div_r_tvalid(div_r_tvalid), .div_r_tready(div_r_tready), .div_r_tdata(div_r_tdata)
  );

  // Segment table and hand-computed single-precision results for it.
  logic [DW-1:0] tbl_a[SC], tbl_b[SC], tbl_l[SC], exp_res[SC];

  task automatic load_base();
    tbl_a   = '{32'h40A00000, 32'h40400000, 32'h41200000, 32'h40E00000,
                32'h3F800000, 32'h40000000, 32'h40C00000, 32'h41100000};
    tbl_b   = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                32'h40400000, 32'h3F000000, 32'h40000000, 32'h3F800000};
    tbl_l   = '{32'h40800000, 32'h40000000, 32'h40000000, 32'h40400000,
                32'h40800000, 32'h3F800000, 32'h41000000, 32'h40000000};
    exp_res = '{32'h3F800000, 32'h3F800000, 32'h40800000, 32'h40000000,
                32'hBF000000, 32'h3FC00000, 32'h3F000000, 32'h40800000};
  endtask

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40A00000_3F800000: return 32'h40800000;
      64'h40400000_3F800000: return 32'h40000000;
      64'h41200000_40000000: return 32'h41000000;
      64'h40E00000_3F800000: return 32'h40C00000;
      64'h3F800000_40400000: return 32'hC0000000;
      64'h40000000_3F000000: return 32'h3FC00000;
      64'h40C00000_40000000: return 32'h40800000;
      64'h41100000_3F800000: return 32'h41000000;
      default:               return 32'h7FC00001;
    endcase
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40800000_40800000: return 32'h3F800000;
      64'h40000000_40000000: return 32'h3F800000;
      64'h41000000_40000000: return 32'h40800000;
      64'h40C00000_40400000: return 32'h40000000;
      64'hC0000000_40800000: return 32'hBF000000;
      64'h40800000_41000000: return 32'h3F000000;
      default:               return 32'h7FC00002;
    endcase
  endfunction

  always @(posedge aclk) begin
    if (rd_en) begin
      rd_a     <= tbl_a[rd_addr];
      rd_b     <= tbl_b[rd_addr];
      rd_lines <= tbl_l[rd_addr];
    end
  end

  // Subtractor stand-in: operand A can be stalled, result is returned with zero wait.
  int            sub_a_stall = 0;
  int            sa_cnt = 0;
  int            sub_txn = 0, sub_proto = 0;
  logic          sa_have = 1'b0, sb_have = 1'b0, sa_wait = 1'b0, sb_wait = 1'b0;
  logic [DW-1:0] sa_val, sb_val, sa_prev, sb_prev, last_sub_a = '0, last_sub_b = '0;
  assign sub_a_tready = (sa_cnt >= sub_a_stall);
  assign sub_b_tready = 1'b1;

  always @(posedge aclk or negedge aresetn) begin : sub_model
    logic an, bn;
    logic [DW-1:0] av, bv;
    if (!aresetn) begin
      sa_cnt <= 0; sa_have <= 1'b0; sb_have <= 1'b0; sa_wait <= 1'b0; sb_wait <= 1'b0;
      sub_r_tvalid <= 1'b0; sub_r_tdata <= '0;
    end else begin
      if (sub_a_tvalid && !sub_a_tready) sa_cnt <= sa_cnt + 1;
      else if (sub_a_tvalid) sa_cnt <= 0;
      if (sa_wait && (!sub_a_tvalid || sub_a_tdata !== sa_prev)) sub_proto <= sub_proto + 1;
      if (sb_wait && (!sub_b_tvalid || sub_b_tdata !== sb_prev)) sub_proto <= sub_proto + 1;
      sa_wait <= sub_a_tvalid && !sub_a_tready; sa_prev <= sub_a_tdata;
      sb_wait <= sub_b_tvalid && !sub_b_tready; sb_prev <= sub_b_tdata;
      if (sub_a_tvalid && sub_a_tready && (sa_have || sub_r_tvalid)) sub_proto <= sub_proto + 1;
      if (sub_b_tvalid && sub_b_tready && (sb_have || sub_r_tvalid)) sub_proto <= sub_proto + 1;
      an = sa_have || (sub_a_tvalid && sub_a_tready);
      bn = sb_have || (sub_b_tvalid && sub_b_tready);
      av = sa_have ? sa_val : sub_a_tdata;
      bv = sb_have ? sb_val : sub_b_tdata;
      if (sub_r_tvalid && sub_r_tready) begin
        sub_r_tvalid <= 1'b0;
        sub_txn <= sub_txn + 1;
      end
      if (an && bn) begin
        sub_r_tvalid <= 1'b1; sub_r_tdata <= fsub(av, bv);
        last_sub_a <= av; last_sub_b <= bv; sa_have <= 1'b0; sb_have <= 1'b0;
      end else begin
        if (sub_a_tvalid && sub_a_tready) begin sa_have <= 1'b1; sa_val <= sub_a_tdata; end
        if (sub_b_tvalid && sub_b_tready) begin sb_have <= 1'b1; sb_val <= sub_b_tdata; end
      end
    end
  end

  // Divider stand-in: operands always accepted, quotient delayed by div_r_delay cycles.
  int            div_r_delay = 0;
  int            dr_cnt = 0;
  int            div_txn = 0, div_proto = 0;
  logic          da_have = 1'b0, db_have = 1'b0;
  logic [DW-1:0] da_val, db_val, last_div_a = '0, last_div_b = '0;
  assign div_a_tready = 1'b1;
  assign div_b_tready = 1'b1;

  always @(posedge aclk or negedge aresetn) begin : div_model
    logic an, bn;
    logic [DW-1:0] av, bv;
    if (!aresetn) begin
      dr_cnt <= 0; da_have <= 1'b0; db_have <= 1'b0;
      div_r_tvalid <= 1'b0; div_r_tdata <= '0;
    end else begin
      if (div_a_tvalid && (da_have || div_r_tvalid)) div_proto <= div_proto + 1;
      if (div_b_tvalid && (db_have || div_r_tvalid)) div_proto <= div_proto + 1;
      an = da_have || div_a_tvalid;
      bn = db_have || div_b_tvalid;
      av = da_have ? da_val : div_a_tdata;
      bv = db_have ? db_val : div_b_tdata;
      if (div_r_tvalid && div_r_tready) begin
        div_r_tvalid <= 1'b0;
        div_txn <= div_txn + 1;
      end
      if (an && bn) begin
        if (dr_cnt >= div_r_delay) begin
          div_r_tvalid <= 1'b1; div_r_tdata <= fdiv(av, bv);
          last_div_a <= av; last_div_b <= bv;
          da_have <= 1'b0; db_have <= 1'b0; dr_cnt <= 0;
        end else begin
          dr_cnt <= dr_cnt + 1;
          da_have <= 1'b1; da_val <= av; db_have <= 1'b1; db_val <= bv;
        end
      end else begin
        if (div_a_tvalid) begin da_have <= 1'b1; da_val <= div_a_tdata; end
        if (div_b_tvalid) begin db_have <= 1'b1; db_val <= div_b_tdata; end
      end
    end
  end

  // Free-running monitor; tasks snapshot counters and compare deltas.
  int            cyc = 0, last_rd = 0, rd_n = 0, wr_n = 0, done_n = 0, sa_vc = 0, sb_vc = 0;
  logic [IW-1:0] wr_addr_log[64];
  logic [DW-1:0] wr_data_log[64];
  int            wr_lat_log[64];

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (rd_en) begin rd_n <= rd_n + 1; last_rd <= cyc; end
    if (wr_en) begin
      wr_addr_log[wr_n % 64] <= wr_addr;
      wr_data_log[wr_n % 64] <= wr_data;
      wr_lat_log[wr_n % 64]  <= cyc - last_rd;
      wr_n <= wr_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (sub_a_tvalid) sa_vc <= sa_vc + 1;
    if (sub_b_tvalid) sb_vc <= sb_vc + 1;
  end

  task automatic wait_done(input int max_cyc, output int cycles, output bit busy_prev,
                           output bit busy_at);
    bit hit = 0;
    cycles = 0;
    busy_prev = busy;
    busy_at = 1'b0;
    while (!hit && cycles < max_cyc) begin
      @(negedge aclk);
      cycles++;
      if (done) begin hit = 1; busy_at = busy; end
      else busy_prev = busy;
    end
    if (!hit) cycles = -1;
  endtask

  task automatic run_batch(input logic [IW:0] sn, output int cycles, output bit bp,
                           output bit ba);
    @(negedge aclk);
    seg_num = sn;
    start = 1'b1;
    wait_done(600, cycles, bp, ba);
    repeat (2) @(negedge aclk);
    start = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, err_seg, rd_en, rd_addr, wr_en, wr_addr, wr_data,
         sub_a_tvalid, sub_a_tdata, sub_b_tvalid, sub_b_tdata, sub_r_tready,
         div_a_tvalid, div_a_tdata, div_b_tvalid, div_b_tdata, div_r_tready} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero during reset (busy=%b done=%b wr_en=%b)",
                         busy, done, wr_en);
    end
    checks++;
    if (err_seg !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got err=%b err_seg=%0d, required 0/0", err, err_seg);
    end
  endtask

  task automatic test_single();
    int cy, wb, st, dt, dn; bit bp, ba;
    load_base();
    wb = wr_n; st = sub_txn; dt = div_txn; dn = done_n;
    run_batch(1, cy, bp, ba);
    checks++; if (cy < 0) begin errors++; $display("FAIL single_timeout: done not seen"); end
    checks++;
    if (last_sub_a !== 32'h40A00000 || last_sub_b !== 32'h3F800000) begin
      errors++; $display("FAIL single_sub_ops: got %h,%h required 40a00000,3f800000", last_sub_a, last_sub_b);
    end
    checks++;
    if (last_div_a !== 32'h40800000 || last_div_b !== 32'h40800000) begin
      errors++; $display("FAIL single_div_ops: got %h,%h required 40800000,40800000", last_div_a, last_div_b);
    end
    checks++; if (wr_n - wb !== 1) begin errors++; $display("FAIL single_wr_count: got %0d required 1", wr_n - wb); end
    checks++;
    if (wr_addr_log[wb % 64] !== 3'd0 || wr_data_log[wb % 64] !== 32'h3F800000) begin
      errors++; $display("FAIL single_wr: got addr %0d data %h required 0 3f800000",
                         wr_addr_log[wb % 64], wr_data_log[wb % 64]);
    end
    checks++; if (wr_lat_log[wb % 64] !== 6) begin errors++; $display("FAIL single_latency: got %0d required 6", wr_lat_log[wb % 64]); end
    checks++; if (done_n - dn !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d required 1", done_n - dn); end
    checks++;
    if (bp !== 1'b1 || ba !== 1'b0) begin
      errors++; $display("FAIL single_busy_edge: busy before/at done %b/%b required 1/0", bp, ba);
    end
    checks++;
    if (sub_txn - st !== 1 || div_txn - dt !== 1) begin
      errors++; $display("FAIL single_txn: sub %0d div %0d required 1 1", sub_txn - st, div_txn - dt);
    end
  endtask

  task automatic test_bypass();
    int cy, wb, dt;
    bit bp, ba;
    logic [DW-1:0] e[3];
    load_base();
    tbl_l[1] = 32'h3F800000;
    e = '{32'h3F800000, 32'h40000000, 32'h40800000};
    wb = wr_n; dt = div_txn;
    run_batch(3, cy, bp, ba);
    checks++; if (cy < 0) begin errors++; $display("FAIL bypass_timeout: done not seen"); end
    checks++; if (wr_n - wb !== 3) begin errors++; $display("FAIL bypass_wr_count: got %0d required 3", wr_n - wb); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_log[(wb+i) % 64] !== IW'(i) || wr_data_log[(wb+i) % 64] !== e[i]) begin
        errors++; $display("FAIL bypass_wr%0d: got addr %0d data %h required %0d %h", i,
                           wr_addr_log[(wb+i) % 64], wr_data_log[(wb+i) % 64], i, e[i]);
      end
    end
    checks++; if (div_txn - dt !== 2) begin errors++; $display("FAIL bypass_div_txn: got %0d required 2", div_txn - dt); end
    checks++; if (wr_lat_log[(wb+1) % 64] !== 4) begin errors++; $display("FAIL bypass_latency: got %0d required 4", wr_lat_log[(wb+1) % 64]); end
  endtask

  task automatic test_zero_lines();
    int cy, wb;
    bit bp, ba;
    logic [DW-1:0] e[4];
    load_base();
    tbl_l[2] = 32'h80000000;
    tbl_l[3] = 32'h00000000;
    e = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000};
    wb = wr_n;
    run_batch(4, cy, bp, ba);
    checks++; if (cy < 0) begin errors++; $display("FAIL zero_timeout: done not seen"); end
    checks++; if (wr_n - wb !== 4) begin errors++; $display("FAIL zero_wr_count: got %0d required 4", wr_n - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr_log[(wb+i) % 64] !== IW'(i) || wr_data_log[(wb+i) % 64] !== e[i]) begin
        errors++; $display("FAIL zero_wr%0d: got addr %0d data %h required %0d %h", i,
                           wr_addr_log[(wb+i) % 64], wr_data_log[(wb+i) % 64], i, e[i]);
      end
    end
    checks++;
    if (err !== 1'b1 || err_seg !== 3'd2) begin
      errors++; $display("FAIL zero_err: got err=%b err_seg=%0d required 1 2", err, err_seg);
    end
    load_base();
    run_batch(1, cy, bp, ba);
    checks++;
    if (err !== 1'b0 || err_seg !== 3'd0) begin
      errors++; $display("FAIL zero_err_clear: got err=%b err_seg=%0d required 0 0", err, err_seg);
    end
  endtask

  task automatic test_backpressure();
    int cy, wb, st, dt, a0, b0;
    bit bp, ba;
    load_base();
    sub_a_stall = 5;
    div_r_delay = 10;
    wb = wr_n; st = sub_txn; dt = div_txn; a0 = sa_vc; b0 = sb_vc;
    run_batch(1, cy, bp, ba);
    sub_a_stall = 0;
    div_r_delay = 0;
    checks++; if (cy < 0) begin errors++; $display("FAIL bp_timeout: done not seen"); end
    checks++; if (sb_vc - b0 !== 1) begin errors++; $display("FAIL bp_sub_b_valid_cycles: got %0d required 1", sb_vc - b0); end
    checks++; if (sa_vc - a0 !== 6) begin errors++; $display("FAIL bp_sub_a_valid_cycles: got %0d required 6", sa_vc - a0); end
    checks++;
    if (wr_n - wb !== 1 || wr_data_log[wb % 64] !== 32'h3F800000) begin
      errors++; $display("FAIL bp_wr: got count %0d data %h required 1 3f800000", wr_n - wb, wr_data_log[wb % 64]);
    end
    checks++; if (wr_lat_log[wb % 64] !== 21) begin errors++; $display("FAIL bp_latency: got %0d required 21", wr_lat_log[wb % 64]); end
    checks++;
    if (sub_txn - st !== 1 || div_txn - dt !== 1) begin
      errors++; $display("FAIL bp_txn: sub %0d div %0d required 1 1", sub_txn - st, div_txn - dt);
    end
  endtask

  task automatic test_reset_mid();
    int cy, wb;
    bit bp, ba, hit;
    load_base();
    div_r_delay = 20;
    wb = wr_n;
    hit = 0;
    @(negedge aclk);
    seg_num = 3;
    start = 1'b1;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge aclk);
      if (wr_n == wb + 1 && div_r_tready) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach: segment 1 divider wait not reached"); end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, sub_a_tvalid, sub_b_tvalid, sub_r_tready,
         div_a_tvalid, div_b_tvalid, div_r_tready, err} !== '0) begin
      errors++; $display("FAIL rmid_outputs: got busy=%b wr_en=%b div_r_tready=%b required all 0",
                         busy, wr_en, div_r_tready);
    end
    repeat (3) @(negedge aclk);
    start = 1'b0;
    checks++; if (wr_n - wb !== 1) begin errors++; $display("FAIL rmid_partial: got %0d writes required 1", wr_n - wb); end
    aresetn = 1'b1;
    div_r_delay = 0;
    repeat (2) @(negedge aclk);
    wb = wr_n;
    run_batch(2, cy, bp, ba);
    checks++; if (wr_n - wb !== 2) begin errors++; $display("FAIL rmid_restart_count: got %0d required 2", wr_n - wb); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_addr_log[(wb+i) % 64] !== IW'(i) || wr_data_log[(wb+i) % 64] !== exp_res[i]) begin
        errors++; $display("FAIL rmid_wr%0d: got addr %0d data %h required %0d %h", i,
                           wr_addr_log[(wb+i) % 64], wr_data_log[(wb+i) % 64], i, exp_res[i]);
      end
    end
  endtask

  task automatic test_count_bounds();
    int cy, wb, rn, dn, dt;
    bit bp, ba;
    load_base();
    wb = wr_n; rn = rd_n;
    @(negedge aclk);
    seg_num = 0;
    start = 1'b1;
    wait_done(20, cy, bp, ba);
    checks++; if (cy !== 1) begin errors++; $display("FAIL n0_done_delay: got %0d cycles required 1", cy); end
    checks++;
    if (rd_n !== rn || wr_n !== wb || ba !== 1'b0) begin
      errors++; $display("FAIL n0_activity: rd %0d wr %0d busy %b required 0 0 0", rd_n - rn, wr_n - wb, ba);
    end
    start = 1'b0;
    repeat (2) @(negedge aclk);
    wb = wr_n; dn = done_n; dt = div_txn;
    run_batch(15, cy, bp, ba);
    checks++; if (cy < 0) begin errors++; $display("FAIL nmax_timeout: done not seen"); end
    checks++; if (wr_n - wb !== 8) begin errors++; $display("FAIL nmax_wr_count: got %0d required 8", wr_n - wb); end
    for (int i = 0; i < SC; i++) begin
      checks++;
      if (wr_addr_log[(wb+i) % 64] !== IW'(i) || wr_data_log[(wb+i) % 64] !== exp_res[i]) begin
        errors++; $display("FAIL nmax_wr%0d: got addr %0d data %h required %0d %h", i,
                           wr_addr_log[(wb+i) % 64], wr_data_log[(wb+i) % 64], i, exp_res[i]);
      end
    end
    checks++;
    if (done_n - dn !== 1 || div_txn - dt !== 7) begin
      errors++; $display("FAIL nmax_done_div: done %0d div %0d required 1 7", done_n - dn, div_txn - dt);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (sub_proto !== 0 || div_proto !== 0) begin
      errors++; $display("FAIL protocol: sub violations %0d div violations %0d required 0 0", sub_proto, div_proto);
    end
  endtask

  initial begin
    load_base();
    repeat (3) @(negedge aclk);
    test_reset();
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    test_single();
    test_bypass();
    test_zero_lines();
    test_backpressure();
    test_reset_mid();
    test_count_bounds();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
